irq_conditioner: RTL and testbench

//  Conditions the raw external interrupt pin (push-button) before it reaches the core's out_interruption input.

---
 rtl/irq_conditioner.sv | 144 ++++++++++++++
 tb/tb_irq_conditioner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_conditioner.sv
// Push-button interrupt conditioner: synchronises the raw pin, debounces both edges, and emits one
// fixed-width request pulse per accepted press. Also exposes the debounced level and a press counter.
module irq_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             irq_in,
    input  logic             irq_enable,
    output logic             irq_req,
    output logic             irq_level,
    output logic             busy,
    output logic [CNT_W-1:0] press_cnt
);

    // state    | meaning
    // IDLE     | pin released and debounced low, waiting for a press
    // DB_HIGH  | pin seen high, counting stable high samples
    // ASSERT   | press accepted with irq_enable set, irq_req pulse in progress
    // HELD     | press accepted, waiting for the pin to drop
    // DB_LOW   | pin seen low, counting stable low samples

    localparam int MAX_CYC = (DEBOUNCE_CYCLES > PULSE_CYCLES) ? DEBOUNCE_CYCLES : PULSE_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam logic [TMR_W-1:0] DB_LOAD = TMR_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] PL_LOAD = TMR_W'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DB_HIGH = 3'd1,
        ST_ASSERT  = 3'd2,
        ST_HELD    = 3'd3,
        ST_DB_LOW  = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       db_cnt_q, db_cnt_d;
    logic [TMR_W-1:0]       pls_cnt_q, pls_cnt_d;
    logic                   irq_req_q, irq_req_d;
    logic                   irq_level_q, irq_level_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       press_cnt_q, press_cnt_d;
    logic                   pin_s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
    assign pin_s  = sync_q[SYNC_STAGES-1];

    // Both timers are down-counters: loaded with N-1 on entry, terminal count at zero.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        pls_cnt_d   = pls_cnt_q;
        irq_req_d   = 1'b0;
        irq_level_d = irq_level_q;
        press_cnt_d = press_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pin_s) begin
                    state_d  = ST_DB_HIGH;
                    db_cnt_d = DB_LOAD;
                end
            end
            ST_DB_HIGH: begin
                if (!pin_s) begin
                    state_d = ST_IDLE;
                end else if (db_cnt_q == '0) begin
                    irq_level_d = 1'b1;
                    press_cnt_d = press_cnt_q + CNT_W'(1);
                    if (irq_enable) begin
                        state_d   = ST_ASSERT;
                        pls_cnt_d = PL_LOAD;
                        irq_req_d = 1'b1;
                    end else begin
                        state_d = ST_HELD;
                    end
                end else begin
                    db_cnt_d = db_cnt_q - TMR_W'(1);
                end
            end
            ST_ASSERT: begin
                if (pls_cnt_q == '0) begin
                    state_d = ST_HELD;
                end else begin
                    pls_cnt_d = pls_cnt_q - TMR_W'(1);
                    irq_req_d = 1'b1;
                end
            end
            ST_HELD: begin
                if (!pin_s) begin
                    state_d  = ST_DB_LOW;
                    db_cnt_d = DB_LOAD;
                end
            end
            ST_DB_LOW: begin
                if (pin_s) begin
                    state_d = ST_HELD;
                end else if (db_cnt_q == '0) begin
                    state_d     = ST_IDLE;
                    irq_level_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q      <= '0;
            state_q     <= ST_IDLE;
            db_cnt_q    <= '0;
            pls_cnt_q   <= '0;
            irq_req_q   <= 1'b0;
            irq_level_q <= 1'b0;
            busy_q      <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            pls_cnt_q   <= pls_cnt_d;
            irq_req_q   <= irq_req_d;
            irq_level_q <= irq_level_d;
            busy_q      <= busy_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign irq_req   = irq_req_q;
    assign irq_level = irq_level_q;
    assign busy      = busy_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_irq_conditioner.sv
// Directed bench for irq_conditioner: default-parameter instance plus a DEBOUNCE=1/PULSE=1 instance.
module tb_irq_conditioner;

    logic       clk = 1'b0;
    logic       resetn;
    logic       irq_in, irq1_in;
    logic       irq_enable;
    logic       req0, lvl0, busy0;
    logic [7:0] cnt0;
    logic       req1, lvl1, busy1;
    logic [7:0] cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_conditioner dut (
        .clk(clk), .resetn(resetn), .irq_in(irq_in), .irq_enable(irq_enable),
        .irq_req(req0), .irq_level(lvl0), .busy(busy0), .press_cnt(cnt0)
    );

    irq_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .PULSE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .resetn(resetn), .irq_in(irq1_in), .irq_enable(irq_enable),
        .irq_req(req1), .irq_level(lvl1), .busy(busy1), .press_cnt(cnt1)
    );

    typedef struct {
        bit         d1;
        logic       irq;
        logic       en;
        int         n;
        logic       req;
        logic       lvl;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(bit d1, logic irq, logic en, int n,
                                logic req, logic lvl, logic bsy, logic [7:0] cnt);
        vec_t v;
        v.d1 = d1; v.irq = irq; v.en = en; v.n = n;
        v.req = req; v.lvl = lvl; v.busy = bsy; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    // Clean press on the default instance: req rises 19 edges after the pin, lasts 4 cycles.
    function automatic void add_press(logic en, logic [7:0] c, int hold);
        logic [7:0] c1;
        c1 = c + 8'd1;
        add(0, 1, en, 2, 0, 0, 0, c);
        add(0, 1, en, 16, 0, 0, 1, c);
        if (en) begin
            add(0, 1, en, 1, 1, 1, 1, c1);
            add(0, 1, en, 3, 1, 1, 1, c1);
            add(0, 1, en, 1, 0, 1, 1, c1);
            add(0, 1, en, hold, 0, 1, 1, c1);
        end else begin
            add(0, 1, en, 1, 0, 1, 1, c1);
            add(0, 1, en, hold, 0, 1, 1, c1);
        end
    endfunction

    function automatic void add_release(logic [7:0] c);
        add(0, 0, 1, 18, 0, 1, 1, c);
        add(0, 0, 1, 1, 0, 0, 0, c);
        add(0, 0, 1, 5, 0, 0, 0, c);
    endfunction

    task automatic run_vecs(input string tag);
        logic       a_req, a_lvl, a_busy;
        logic [7:0] a_cnt;
        foreach (vecs[i]) begin
            if (vecs[i].d1) irq1_in = vecs[i].irq;
            else            irq_in  = vecs[i].irq;
            irq_enable = vecs[i].en;
            for (int k = 0; k < vecs[i].n; k++) begin
                tick();
                a_req  = vecs[i].d1 ? req1  : req0;
                a_lvl  = vecs[i].d1 ? lvl1  : lvl0;
                a_busy = vecs[i].d1 ? busy1 : busy0;
                a_cnt  = vecs[i].d1 ? cnt1  : cnt0;
                chk($sformatf("%s[%0d].%0d.irq_req", tag, i, k), 32'(a_req), 32'(vecs[i].req));
                chk($sformatf("%s[%0d].%0d.irq_level", tag, i, k), 32'(a_lvl), 32'(vecs[i].lvl));
                chk($sformatf("%s[%0d].%0d.busy", tag, i, k), 32'(a_busy), 32'(vecs[i].busy));
                chk($sformatf("%s[%0d].%0d.press_cnt", tag, i, k), 32'(a_cnt), 32'(vecs[i].cnt));
            end
        end
        vecs.delete();
    endtask

    int hi;

    initial begin
        resetn     = 1'b0;
        irq_in     = 1'b0;
        irq1_in    = 1'b0;
        irq_enable = 1'b1;
        #1;
        chk("reset.outputs", {req0, lvl0, busy0, cnt0}, 32'h0);
        tick();
        tick();
        resetn = 1'b1;

        // clean press held 100 cycles, then clean release
        add_press(1, 8'd0, 77);
        add_release(8'd1);
        run_vecs("clean");

        // 10-cycle glitch is rejected
        add(0, 1, 1, 2, 0, 0, 0, 8'd1);
        add(0, 1, 1, 8, 0, 0, 1, 8'd1);
        add(0, 0, 1, 2, 0, 0, 1, 8'd1);
        add(0, 0, 1, 1, 0, 0, 0, 8'd1);
        add(0, 0, 1, 10, 0, 0, 0, 8'd1);
        run_vecs("glitch");

        // disabled press counts but no pulse; enabled press whose enable drops mid-pulse
        add_press(0, 8'd1, 10);
        add_release(8'd2);
        add(0, 1, 1, 2, 0, 0, 0, 8'd2);
        add(0, 1, 1, 16, 0, 0, 1, 8'd2);
        add(0, 1, 1, 1, 1, 1, 1, 8'd3);
        add(0, 1, 0, 3, 1, 1, 1, 8'd3);
        add(0, 1, 0, 1, 0, 1, 1, 8'd3);
        add(0, 1, 0, 10, 0, 1, 1, 8'd3);
        add_release(8'd3);
        run_vecs("disable");

        // bouncy release: toggles every 3 cycles for 30 cycles, no second pulse
        add_press(1, 8'd3, 10);
        for (int seg = 0; seg < 10; seg++)
            add(0, logic'(seg % 2), 1, 3, 0, 1, 1, 8'd4);
        add_release(8'd4);
        run_vecs("bounce");

        // wrap: 256 presses from reset
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("wrap.reset_cnt", 32'(cnt0), 32'h0);
        irq_enable = 1'b1;
        for (int i = 0; i < 256; i++) begin
            hi = 0;
            irq_in = 1'b1;
            repeat (25) begin
                tick();
                if (req0) hi++;
            end
            irq_in = 1'b0;
            repeat (25) begin
                tick();
                if (req0) hi++;
            end
            chk($sformatf("wrap[%0d].pulse_len", i), 32'(hi), 32'd4);
            chk($sformatf("wrap[%0d].press_cnt", i), 32'(cnt0), 32'((i + 1) % 256));
            chk($sformatf("wrap[%0d].irq_level", i), 32'(lvl0), 32'd0);
        end

        // reset asserted mid-pulse
        irq_in = 1'b1;
        repeat (20) tick();
        chk("midrst.req_before", 32'(req0), 32'd1);
        chk("midrst.cnt_before", 32'(cnt0), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst.req_async", 32'(req0), 32'd0);
        chk("midrst.outputs", {lvl0, busy0, cnt0}, 32'h0);
        irq_in = 1'b0;
        tick();
        tick();
        chk("midrst.held", {req0, lvl0, busy0, cnt0}, 32'h0);
        resetn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk($sformatf("midrst.after[%0d]", k), {req0, busy0}, 32'h0);
        end

        // DEBOUNCE_CYCLES=1, PULSE_CYCLES=1 instance
        add(1, 1, 1, 2, 0, 0, 0, 8'd0);
        add(1, 1, 1, 1, 0, 0, 1, 8'd0);
        add(1, 1, 1, 1, 1, 1, 1, 8'd1);
        add(1, 1, 1, 1, 0, 1, 1, 8'd1);
        add(1, 1, 1, 5, 0, 1, 1, 8'd1);
        add(1, 0, 1, 3, 0, 1, 1, 8'd1);
        add(1, 0, 1, 1, 0, 0, 0, 8'd1);
        add(1, 0, 1, 3, 0, 0, 0, 8'd1);
        run_vecs("fast");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
